// File: rtl/spi_slave_cmd_dec.sv
// SPI slave command decoder (sclk domain): decodes the opcode, programs the shifter phase
// length, captures the start address and issues auto-incrementing write requests.
// Optional: define SPI_SLAVE_ADDR_WRAP_EN to keep bursts inside a 4 KiB page.
module spi_slave_cmd_dec #(
  parameter logic [7:0]  CMD_WR_SERIAL = 8'h02,
  parameter logic [7:0]  CMD_WR_QUAD   = 8'h32,
  parameter logic [31:0] ADDR_INC      = 32'd4
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic [7:0]  rx_counter,
  output logic        rx_counter_upd,
  output logic        rx_en_quad,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        overflow,
  output logic        cmd_err
);

  typedef enum logic [1:0] {
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  state_t      state, state_nxt;
  logic        first;
  logic        wr_accept;
  logic        data_load;
  logic        data_drop;
  logic [31:0] addr_next;
  logic [7:0]  opcode;

  assign opcode    = rx_data[7:0];
  assign wr_accept = wr_valid && wr_ready;
  assign data_load = (state == ST_DATA) && rx_valid && (!wr_valid || wr_ready);
  assign data_drop = (state == ST_DATA) && rx_valid && wr_valid && !wr_ready;

`ifdef SPI_SLAVE_ADDR_WRAP_EN
  assign addr_next = {wr_addr[31:12], wr_addr[11:0] + ADDR_INC[11:0]};
`else
  assign addr_next = wr_addr + ADDR_INC;
`endif

  // A received word overrides the post-reset command-length load in the same cycle.
  always_comb begin
    state_nxt      = state;
    rx_counter_upd = 1'b0;
    rx_counter     = '0;
    if (first) begin
      rx_counter_upd = 1'b1;
      rx_counter     = 8'd7;
    end
    if (rx_valid) begin
      case (state)
        ST_CMD: begin
          rx_counter_upd = 1'b0;
          rx_counter     = '0;
          if (opcode == CMD_WR_SERIAL) begin
            rx_counter_upd = 1'b1;
            rx_counter     = 8'd31;
            state_nxt      = ST_ADDR;
          end else if (opcode == CMD_WR_QUAD) begin
            rx_counter_upd = 1'b1;
            rx_counter     = 8'd7;
            state_nxt      = ST_ADDR;
          end else begin
            state_nxt      = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          rx_counter_upd = 1'b1;
          rx_counter     = rx_en_quad ? 8'd7 : 8'd31;
          state_nxt      = ST_DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CMD;
      first      <= 1'b1;
      rx_en_quad <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_valid   <= 1'b0;
      overflow   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      first <= 1'b0;

      if ((state == ST_CMD) && rx_valid) begin
        if (opcode == CMD_WR_SERIAL)
          rx_en_quad <= 1'b0;
        else if (opcode == CMD_WR_QUAD)
          rx_en_quad <= 1'b1;
        else
          cmd_err <= 1'b1;
      end

      if ((state == ST_ADDR) && rx_valid)
        wr_addr <= rx_data;
      else if (wr_accept)
        wr_addr <= addr_next;

      if (data_load) begin
        wr_data  <= rx_data;
        wr_valid <= 1'b1;
      end else if (wr_accept) begin
        wr_valid <= 1'b0;
      end

      if (data_drop)
        overflow <= 1'b1;
    end
  end

endmodule
